automata_step_ctrl: RTL and testbench

- Grid-level sequencer and initiator for the cellular-automaton cell array. Every cell is a responder on a shared control bus: enable, rst, step button level.
- Turns raw board inputs (step button, run button, enable switch) into clean, protocol-correct bus signals.
- Guarantees cells leave their load state before the first step, and that every generation step is a clean high/low level the cells' internal edge detectors see exactly once.
- Adds a free-running auto-step mode and a generation counter for the display.

---
 rtl/automata_step_ctrl_if.sv | 53 +++++
 rtl/automata_step_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_automata_step_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/automata_step_ctrl_if.sv
// Control-bus bundle between the grid sequencer and the board/cell array.
//
// Board side (into the sequencer):
//   btn_step_raw  raw step push-button, asynchronous
//   btn_run_raw   raw run/pause push-button, asynchronous
//   sw_enable     raw enable slide switch, asynchronous; 0 = hold grid in load
// Cell/display side (out of the sequencer, all registered):
//   cell_enable   broadcast enable to every cell
//   cell_rst      broadcast one-cycle synchronous restart to every cell
//   cell_step     broadcast step level, seen by each cell's edge detector
//   gen_count     generations stepped since the last load (GEN_W bits)
//   running       auto-step mode active
//   busy          sequencer is in LOAD, STEP_HI or STEP_LO
//
// The sequencer drives the bus through the master modport; the board /
// observer side uses the slave modport.
interface automata_step_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             btn_step_raw;
    logic             btn_run_raw;
    logic             sw_enable;
    logic             cell_enable;
    logic             cell_rst;
    logic             cell_step;
    logic [GEN_W-1:0] gen_count;
    logic             running;
    logic             busy;

    modport master (
        input  btn_step_raw,
        input  btn_run_raw,
        input  sw_enable,
        output cell_enable,
        output cell_rst,
        output cell_step,
        output gen_count,
        output running,
        output busy
    );

    modport slave (
        output btn_step_raw,
        output btn_run_raw,
        output sw_enable,
        input  cell_enable,
        input  cell_rst,
        input  cell_step,
        input  gen_count,
        input  running,
        input  busy
    );
endinterface

// File: rtl/automata_step_ctrl.sv
// Grid-level sequencer for the cellular-automaton array.
//
// Conditions the raw board inputs (2-FF synchronizers on all three, stability
// debouncers plus rising-edge request pulses on the two buttons) and drives the
// shared cell control bus: a one-cycle cell_rst at the start of every load, a
// settle period with cell_enable high and no step, then clean high/low step
// levels, either on a manual press or automatically every AUTO_PERIOD cycles
// while running. A generation counter tracks steps since the last load.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   automata_step_ctrl_if.master (raw inputs in, cell bus/status out)
module automata_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int STEP_HOLD       = 2,
    parameter int LOAD_CYCLES     = 2,
    parameter int GEN_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    automata_step_ctrl_if.master  bus
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PER_W    = $clog2(AUTO_PERIOD + 1);
    localparam int HOLD_MAX = (STEP_HOLD > LOAD_CYCLES) ? STEP_HOLD : LOAD_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(AUTO_PERIOD - 1);
    localparam logic [HOLD_W-1:0] STEP_LAST = HOLD_W'(STEP_HOLD - 1);
    localparam logic [HOLD_W-1:0] LOAD_LAST = HOLD_W'(LOAD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = step, bit 1 = run, bit 2 = enable
    // ------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;

    assign raw = {bus.sw_enable, bus.btn_run_raw, bus.btn_step_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Button debouncers and rising-edge request pulses (gi 0 = step, 1 = run)
    // ------------------------------------------------------------------
    logic [1:0] btn_req;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [DB_W-1:0] db_cnt_reg;
            logic            db_reg;
            logic            db_prev_reg;
            logic            req_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    db_cnt_reg  <= '0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    req_reg     <= 1'b0;
                end else begin
                    // Counter only runs while the synchronized value disagrees
                    // with the debounced one; any agreeing sample restarts it.
                    if (sync2_reg[gi] == db_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        db_reg     <= sync2_reg[gi];
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                    db_prev_reg <= db_reg;
                    req_reg     <= db_reg & ~db_prev_reg;
                end
            end

            assign btn_req[gi] = req_reg;
        end
    endgenerate

    logic step_req;
    logic run_req;
    logic sw_sync;

    assign step_req = btn_req[0];
    assign run_req  = btn_req[1];
    assign sw_sync  = sync2_reg[2];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        READY   = 3'd2,
        STEP_HI = 3'd3,
        STEP_LO = 3'd4
    } state_t;

    state_t             state_reg;
    logic               cell_enable_reg;
    logic               cell_rst_reg;
    logic               cell_step_reg;
    logic [GEN_W-1:0]   gen_reg;
    logic               running_reg;
    logic               busy_reg;
    logic [PER_W-1:0]   period_reg;
    logic [HOLD_W-1:0]  hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cell_enable_reg <= 1'b0;
            cell_rst_reg    <= 1'b0;
            cell_step_reg   <= 1'b0;
            gen_reg         <= '0;
            running_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            period_reg      <= '0;
            hold_reg        <= '0;
        end else begin
            cell_rst_reg <= 1'b0;

            if (state_reg != IDLE && !sw_sync) begin
                // Switch off: abandon whatever is in flight; running survives.
                state_reg       <= IDLE;
                cell_enable_reg <= 1'b0;
                cell_step_reg   <= 1'b0;
                gen_reg         <= '0;
                busy_reg        <= 1'b0;
                period_reg      <= '0;
                hold_reg        <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        gen_reg    <= '0;
                        period_reg <= '0;
                        if (sw_sync) begin
                            state_reg       <= LOAD;
                            cell_enable_reg <= 1'b1;
                            cell_rst_reg    <= 1'b1;
                            busy_reg        <= 1'b1;
                            hold_reg        <= '0;
                        end
                    end

                    LOAD: begin
                        if (hold_reg == LOAD_LAST) begin
                            state_reg <= READY;
                            busy_reg  <= 1'b0;
                            hold_reg  <= '0;
                        end else begin
                            hold_reg <= hold_reg + HOLD_W'(1);
                        end
                    end

                    READY: begin
                        if (running_reg) begin
                            if (period_reg == PER_LAST) begin
                                state_reg     <= STEP_HI;
                                cell_step_reg <= 1'b1;
                                gen_reg       <= gen_reg + GEN_W'(1);
                                busy_reg      <= 1'b1;
                                hold_reg      <= '0;
                                period_reg    <= '0;
                            end else begin
                                period_reg <= period_reg + PER_W'(1);
                            end
                        end else if (step_req) begin
                            state_reg     <= STEP_HI;
                            cell_step_reg <= 1'b1;
                            gen_reg       <= gen_reg + GEN_W'(1);
                            busy_reg      <= 1'b1;
                            hold_reg      <= '0;
                        end
                    end

                    STEP_HI: begin
                        if (hold_reg == STEP_LAST) begin
                            state_reg     <= STEP_LO;
                            cell_step_reg <= 1'b0;
                            hold_reg      <= '0;
                        end else begin
                            hold_reg <= hold_reg + HOLD_W'(1);
                        end
                    end

                    STEP_LO: begin
                        if (hold_reg == STEP_LAST) begin
                            state_reg <= READY;
                            busy_reg  <= 1'b0;
                            hold_reg  <= '0;
                        end else begin
                            hold_reg <= hold_reg + HOLD_W'(1);
                        end
                    end

                    default: begin
                        state_reg       <= IDLE;
                        cell_enable_reg <= 1'b0;
                        cell_step_reg   <= 1'b0;
                        busy_reg        <= 1'b0;
                    end
                endcase
            end

            // Run toggle sits last so that starting auto mode always begins a
            // fresh period. The READY branch above already used the old value,
            // so a step and a run request in the same cycle both take effect.
            if (state_reg != IDLE && run_req) begin
                running_reg <= ~running_reg;
                if (!running_reg) begin
                    period_reg <= '0;
                end
            end
        end
    end

    assign bus.cell_enable = cell_enable_reg;
    assign bus.cell_rst    = cell_rst_reg;
    assign bus.cell_step   = cell_step_reg;
    assign bus.gen_count   = gen_reg;
    assign bus.running     = running_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_automata_step_ctrl.sv
// Bench for automata_step_ctrl with small parameters
// (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, STEP_HOLD=2, LOAD_CYCLES=2, GEN_W=4).
// A vector table covers reset, load and one clean manual step cycle by cycle;
// hand-written sequences cover bounce, auto-run, enable removal, wrap,
// reset mid-step and simultaneous step/run requests.
module tb_automata_step_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    automata_step_ctrl_if #(.GEN_W(4)) bus ();

    automata_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD(10),
        .STEP_HOLD(2),
        .LOAD_CYCLES(2),
        .GEN_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       step;
        logic       run;
        logic       sw;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // {cell_enable, cell_rst, cell_step, gen_count[3:0], running, busy}
    function automatic logic [8:0] mk(input logic en, input logic cr, input logic st,
                                      input logic [3:0] g, input logic rn, input logic bz);
        return {en, cr, st, g, rn, bz};
    endfunction

    function automatic logic [8:0] outs();
        return {bus.cell_enable, bus.cell_rst, bus.cell_step, bus.gen_count,
                bus.running, bus.busy};
    endfunction

    initial begin
        logic prev;
        int   nr;
        int   rise_at [4];
        int   gen_at [17];
        bit   found;
        int   cnt;

        bus.btn_step_raw = 1'b0;
        bus.btn_run_raw  = 1'b0;
        bus.sw_enable    = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2, mk(0, 0, 0, 4'd0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2, mk(0, 0, 0, 4'd0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1, mk(1, 1, 0, 4'd0, 0, 1)};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1, mk(1, 0, 0, 4'd0, 0, 1)};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, mk(1, 0, 0, 4'd0, 0, 0)};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 7, mk(1, 0, 0, 4'd0, 0, 0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1, mk(1, 0, 1, 4'd1, 0, 1)};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1, mk(1, 0, 1, 4'd1, 0, 1)};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1, mk(1, 0, 0, 4'd1, 0, 1)};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1, mk(1, 0, 0, 4'd1, 0, 1)};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1, mk(1, 0, 0, 4'd1, 0, 0)};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8, mk(1, 0, 0, 4'd1, 0, 0)};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 12, mk(1, 0, 0, 4'd1, 0, 0)};

        // Reset state
        repeat (3) tick();
        check("reset_outputs", 32'(outs()), 32'(mk(0, 0, 0, 4'd0, 0, 0)));
        rst = 1'b0;

        // Table: idle, load sequence, one clean 20-cycle manual press
        for (int i = 0; i < 13; i++) begin
            bus.btn_step_raw = vecs[i].step;
            bus.btn_run_raw  = vecs[i].run;
            bus.sw_enable    = vecs[i].sw;
            for (int k = 0; k < vecs[i].n; k++) tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Bouncing step button: exactly one step
        nr   = 0;
        prev = bus.cell_step;
        for (int i = 0; i < 54; i++) begin
            if (i < 12) bus.btn_step_raw = ((i / 2) % 2) == 0;
            else if (i < 42) bus.btn_step_raw = 1'b1;
            else bus.btn_step_raw = 1'b0;
            tick();
            if (!prev && bus.cell_step) nr++;
            prev = bus.cell_step;
        end
        check("bounce_steps", 32'(nr), 32'd1);
        check("bounce_gen", 32'(bus.gen_count), 32'd2);

        // Run press, auto steps every 14 cycles, manual press ignored
        bus.btn_run_raw = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.running) found = 1;
        end
        check("run_on", 32'(found), 32'd1);
        bus.btn_run_raw = 1'b0;
        nr   = 0;
        prev = bus.cell_step;
        for (int i = 1; i <= 60; i++) begin
            bus.btn_step_raw = (i >= 3 && i < 25);
            tick();
            if (!prev && bus.cell_step) begin
                if (nr < 4) rise_at[nr] = i;
                nr++;
            end
            prev = bus.cell_step;
        end
        bus.btn_step_raw = 1'b0;
        check("auto_rises", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("auto_rise%0d", k), 32'(rise_at[k]), 32'(10 + 14 * k));
        check("auto_gen", 32'(bus.gen_count), 32'd6);
        check("auto_running", 32'(bus.running), 32'd1);

        // Enable dropped during STEP_HI
        found = 0;
        prev  = bus.cell_step;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (!prev && bus.cell_step) found = 1;
            prev = bus.cell_step;
        end
        check("drop_found_step", 32'(found), 32'd1);
        bus.sw_enable = 1'b0;
        repeat (3) tick();
        check("drop_outputs", 32'(outs()), 32'(mk(0, 0, 0, 4'd0, 1, 0)));

        // Run request while IDLE is ignored
        bus.btn_run_raw = 1'b1;
        repeat (12) tick();
        bus.btn_run_raw = 1'b0;
        repeat (12) tick();
        check("idle_run_ignored", 32'(outs()), 32'(mk(0, 0, 0, 4'd0, 1, 0)));

        // Re-enable: cell_rst pulse, LOAD, running still set
        bus.sw_enable = 1'b1;
        repeat (3) tick();
        check("reload_rst", 32'(outs()), 32'(mk(1, 1, 0, 4'd0, 1, 1)));

        // 17 auto steps from the fresh load: wrap 15 -> 0 -> 1
        nr   = 0;
        prev = bus.cell_step;
        for (int i = 0; i < 400 && nr < 17; i++) begin
            tick();
            if (!prev && bus.cell_step) begin
                gen_at[nr] = int'(bus.gen_count);
                nr++;
            end
            prev = bus.cell_step;
        end
        check("wrap_rises", 32'(nr), 32'd17);
        if (nr == 17) begin
            check("wrap_gen1", 32'(gen_at[0]), 32'd1);
            check("wrap_gen15", 32'(gen_at[14]), 32'd15);
            check("wrap_gen16", 32'(gen_at[15]), 32'd0);
            check("wrap_gen17", 32'(gen_at[16]), 32'd1);
        end

        // Reset mid-step (currently in STEP_HI)
        rst = 1'b1;
        tick();
        check("rst_midstep", 32'(outs()), 32'(mk(0, 0, 0, 4'd0, 0, 0)));
        rst = 1'b0;
        repeat (6) tick();
        check("after_rst_ready", 32'(outs()), 32'(mk(1, 0, 0, 4'd0, 0, 0)));

        // Simultaneous step and run requests in READY, running=0
        bus.btn_step_raw = 1'b1;
        bus.btn_run_raw  = 1'b1;
        found = 0;
        cnt   = 0;
        prev  = bus.cell_step;
        for (int i = 1; i <= 30 && !found; i++) begin
            tick();
            if (!prev && bus.cell_step) begin
                found = 1;
                cnt   = i;
            end
            prev = bus.cell_step;
        end
        check("simul_latency", 32'(cnt), 32'd8);
        check("simul_state", 32'(outs()), 32'(mk(1, 0, 1, 4'd1, 1, 1)));
        bus.btn_step_raw = 1'b0;
        bus.btn_run_raw  = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
